// File: rtl/mem_access_unit.sv
// mem_access_unit: turns byte/half/word load-store requests into word-aligned
// accesses on a unified word-addressed memory. Sub-word stores read the
// containing word first and write it back with the selected lane(s) replaced.
module mem_access_unit #(
   parameter bit BIG_ENDIAN = 1'b0
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req,
   input  logic        wr,
   input  logic [1:0]  size,
   input  logic        sign_ext,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [31:0] rdata,
   output logic [31:0] mem_a,
   output logic [31:0] mem_wd,
   output logic        mem_we,
   input  logic [31:0] mem_rd
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_RD   = 3'd1;
   localparam logic [2:0] S_WR   = 3'd2;
   localparam logic [2:0] S_FIN  = 3'd3;
   localparam logic [2:0] S_ERR  = 3'd4;

   logic [2:0]  state_q, state_d;
   logic [31:0] addr_q, wdata_q, word_q, rdata_q, rdata_d, merged;
   logic [1:0]  size_q;
   logic        wr_q, sext_q;
   logic        misal;
   logic [1:0]  blane;
   logic        hlane;
   logic [7:0]  bsel;
   logic [15:0] hsel;

   // Rejected requests: reserved size or address not aligned to the access size
   assign misal = (size == 2'b11) ||
                  (size == 2'b01 && addr[0]) ||
                  (size == 2'b10 && addr[1:0] != 2'b00);

   // Physical lane inside the word; big-endian mirrors the byte/half index
   assign blane = BIG_ENDIAN ? ~addr_q[1:0] : addr_q[1:0];
   assign hlane = BIG_ENDIAN ? ~addr_q[1]   : addr_q[1];

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (req) begin
            if (misal)                      state_d = S_ERR;
            else if (!wr || size != 2'b10)  state_d = S_RD;
            else                            state_d = S_WR;
         end
         S_RD:    state_d = wr_q ? S_WR : S_FIN;
         S_WR:    state_d = S_FIN;
         S_FIN:   state_d = S_IDLE;
         S_ERR:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Load path: pick the addressed lane out of the memory word and extend it
   always_comb begin
      case (blane)
         2'd0:    bsel = mem_rd[7:0];
         2'd1:    bsel = mem_rd[15:8];
         2'd2:    bsel = mem_rd[23:16];
         default: bsel = mem_rd[31:24];
      endcase
      hsel = hlane ? mem_rd[31:16] : mem_rd[15:0];
      case (size_q)
         2'b00:   rdata_d = {(sext_q ? {24{bsel[7]}}  : 24'h0), bsel};
         2'b01:   rdata_d = {(sext_q ? {16{hsel[15]}} : 16'h0), hsel};
         default: rdata_d = mem_rd;
      endcase
   end

   // Store path: splice right-justified store data into the word read in RD
   always_comb begin
      merged = word_q;
      case (size_q)
         2'b00: begin
            case (blane)
               2'd0:    merged[7:0]   = wdata_q[7:0];
               2'd1:    merged[15:8]  = wdata_q[7:0];
               2'd2:    merged[23:16] = wdata_q[7:0];
               default: merged[31:24] = wdata_q[7:0];
            endcase
         end
         2'b01: begin
            if (hlane) merged[31:16] = wdata_q[15:0];
            else       merged[15:0]  = wdata_q[15:0];
         end
         default: merged = wdata_q;
      endcase
   end

   // State, latched request, read-back word and load result
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         size_q  <= '0;
         wr_q    <= 1'b0;
         sext_q  <= 1'b0;
         word_q  <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == S_IDLE && req) begin
            addr_q  <= addr;
            wdata_q <= wdata;
            size_q  <= size;
            wr_q    <= wr;
            sext_q  <= sign_ext;
         end
         if (state_q == S_RD) begin
            word_q <= mem_rd;
            if (!wr_q) rdata_q <= rdata_d;
         end
      end
   end

   // mem_we decodes straight from state, so reset kills a write immediately
   assign mem_a  = {addr_q[31:2], 2'b00};
   assign mem_wd = merged;
   assign mem_we = (state_q == S_WR);
   assign busy   = (state_q != S_IDLE);
   assign done   = (state_q == S_FIN);
   assign err    = (state_q == S_ERR);
   assign rdata  = rdata_q;

endmodule
